bit_index_encoder: RTL and testbench



---
 rtl/bit_index_encoder.sv | 156 +++++++++++++++
 tb/tb_bit_index_encoder.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bit_index_encoder.sv
// bit_index_encoder
//   Registered priority encoder with valid/ready handshakes on both sides.
//   Single mode emits one beat with the priority set bit; scan mode emits one
//   beat per set bit in priority order. Zero and multi-hot vectors are flagged.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   in_vec/in_mode valid
//   in_ready   block can accept a vector this cycle
//   in_vec     N-bit vector to encode
//   in_mode    0 = single, 1 = scan
//   out_valid  out_idx/flags valid
//   out_ready  consumer accepts current beat
//   out_idx    index of current set bit
//   out_last   final beat for this vector
//   out_zero   latched vector was all zeros
//   out_multi  latched vector had more than one bit set
module bit_index_encoder #(
  parameter int N         = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N-1:0]         in_vec,
  input  logic                 in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [$clog2(N)-1:0] out_idx,
  output logic                 out_last,
  output logic                 out_zero,
  output logic                 out_multi
);

  localparam int IDX_W = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     pend_q, pend_d;
  logic             mode_q, mode_d;
  logic             zero_q, zero_d;
  logic             multi_q, multi_d;

  logic             valid_q, valid_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             ozero_q, ozero_d;
  logic             omulti_q, omulti_d;

  logic             accept;
  logic             beat;

  // Priority index of a vector; 0 when the vector is empty.
  function automatic logic [IDX_W-1:0] prio_idx(input logic [N-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (MSB_FIRST) begin
        if (v[i]) r = IDX_W'(i);
      end else begin
        if (v[N-1-i]) r = IDX_W'(N-1-i);
      end
    end
    return r;
  endfunction

  function automatic logic more_than_one(input logic [N-1:0] v);
    return (v & (v - N'(1))) != '0;
  endfunction

  function automatic logic exactly_one(input logic [N-1:0] v);
    return (v != '0) && !more_than_one(v);
  endfunction

  assign beat     = valid_q & out_ready;
  assign in_ready = (state_q == IDLE) | ((state_q == EMIT) & beat & last_q);
  assign accept   = in_valid & in_ready;

  // Output registers are loaded from the next-state values so the decoded
  // beat appears the cycle after accept/advance with no input-to-output path.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    mode_d   = mode_q;
    zero_d   = zero_q;
    multi_d  = multi_q;
    valid_d  = valid_q;
    idx_d    = idx_q;
    last_d   = last_q;
    ozero_d  = ozero_q;
    omulti_d = omulti_q;

    if (state_q == EMIT && beat) begin
      if (last_q) begin
        state_d = IDLE;
      end else begin
        pend_d = pend_q & ~(N'(1) << idx_q);
      end
    end

    if (accept) begin
      state_d = EMIT;
      pend_d  = in_vec;
      mode_d  = in_mode;
      zero_d  = (in_vec == '0);
      multi_d = more_than_one(in_vec);
    end

    valid_d = (state_d == EMIT);
    if (state_d == EMIT) begin
      idx_d    = prio_idx(pend_d);
      last_d   = zero_d | ~mode_d | exactly_one(pend_d);
      ozero_d  = zero_d;
      omulti_d = multi_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      pend_q   <= '0;
      mode_q   <= 1'b0;
      zero_q   <= 1'b0;
      multi_q  <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      last_q   <= 1'b0;
      ozero_q  <= 1'b0;
      omulti_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      mode_q   <= mode_d;
      zero_q   <= zero_d;
      multi_q  <= multi_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      last_q   <= last_d;
      ozero_q  <= ozero_d;
      omulti_q <= omulti_d;
    end
  end

  assign out_valid = valid_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_zero  = ozero_q;
  assign out_multi = omulti_q;

endmodule

// File: tb/tb_bit_index_encoder.sv
module tb_bit_index_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // DUT 0: N=8, lowest index first
  logic       a_iv = 0, a_ir, a_mode = 0, a_ov, a_or = 0, a_last, a_zero, a_multi;
  logic [7:0] a_vec = '0;
  logic [2:0] a_idx;
  // DUT 1: N=8, highest index first
  logic       b_iv = 0, b_ir, b_mode = 0, b_ov, b_or = 0, b_last, b_zero, b_multi;
  logic [7:0] b_vec = '0;
  logic [2:0] b_idx;
  // DUT 2: N=5, lowest index first
  logic       c_iv = 0, c_ir, c_mode = 0, c_ov, c_or = 0, c_last, c_zero, c_multi;
  logic [4:0] c_vec = '0;
  logic [2:0] c_idx;

  bit_index_encoder #(.N(8), .MSB_FIRST(1'b0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_iv), .in_ready(a_ir), .in_vec(a_vec),
    .in_mode(a_mode), .out_valid(a_ov), .out_ready(a_or), .out_idx(a_idx),
    .out_last(a_last), .out_zero(a_zero), .out_multi(a_multi));

  bit_index_encoder #(.N(8), .MSB_FIRST(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_iv), .in_ready(b_ir), .in_vec(b_vec),
    .in_mode(b_mode), .out_valid(b_ov), .out_ready(b_or), .out_idx(b_idx),
    .out_last(b_last), .out_zero(b_zero), .out_multi(b_multi));

  bit_index_encoder #(.N(5), .MSB_FIRST(1'b0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(c_iv), .in_ready(c_ir), .in_vec(c_vec),
    .in_mode(c_mode), .out_valid(c_ov), .out_ready(c_or), .out_idx(c_idx),
    .out_last(c_last), .out_zero(c_zero), .out_multi(c_multi));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check one beat of DUT 0: valid, index, last, zero, multi
  task automatic beat_a(input string tag, input logic [2:0] idx, input logic last,
                        input logic zero, input logic multi);
    chk({tag, ".valid"}, 64'(a_ov), 64'd1);
    chk({tag, ".idx"},   64'(a_idx), 64'(idx));
    chk({tag, ".last"},  64'(a_last), 64'(last));
    chk({tag, ".zero"},  64'(a_zero), 64'(zero));
    chk({tag, ".multi"}, 64'(a_multi), 64'(multi));
  endtask

  initial begin
    logic [2:0] exp_a [4];
    logic [2:0] exp_b [4];
    logic [2:0] exp_c [3];
    exp_a = '{3'd1, 3'd2, 3'd5, 3'd7};
    exp_b = '{3'd7, 3'd5, 3'd2, 3'd1};
    exp_c = '{3'd0, 3'd2, 3'd4};

    // Reset state
    tick(); tick();
    chk("rst.valid", 64'(a_ov), 64'd0);
    chk("rst.idx",   64'(a_idx), 64'd0);
    chk("rst.last",  64'(a_last), 64'd0);
    chk("rst.zero",  64'(a_zero), 64'd0);
    chk("rst.multi", 64'(a_multi), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("rel.in_ready", 64'(a_ir), 64'd1);
    chk("rel.valid",    64'(a_ov), 64'd0);

    // Single mode, one-hot 0x08
    a_or = 1; a_iv = 1; a_vec = 8'h08; a_mode = 0;
    #1 chk("single.in_ready", 64'(a_ir), 64'd1);
    tick(); a_iv = 0;
    beat_a("single", 3'd3, 1'b1, 1'b0, 1'b0);
    tick();
    chk("single.done", 64'(a_ov), 64'd0);

    // Scan mode 1010_0110, lowest first
    a_iv = 1; a_vec = 8'b1010_0110; a_mode = 1;
    tick(); a_iv = 0;
    #1 chk("scan.in_ready_mid", 64'(a_ir), 64'd0);
    for (int k = 0; k < 4; k++) begin
      beat_a($sformatf("scan%0d", k), exp_a[k], k == 3, 1'b0, 1'b1);
      tick();
    end
    chk("scan.done", 64'(a_ov), 64'd0);

    // Zero vector, single then scan
    for (int m = 0; m < 2; m++) begin
      a_iv = 1; a_vec = 8'h00; a_mode = m[0];
      tick(); a_iv = 0;
      beat_a($sformatf("zero_m%0d", m), 3'd0, 1'b1, 1'b1, 1'b0);
      tick();
      chk($sformatf("zero_m%0d.done", m), 64'(a_ov), 64'd0);
    end

    // Single mode, multi-hot: only the priority index
    a_iv = 1; a_vec = 8'b0110_0000; a_mode = 0;
    tick(); a_iv = 0;
    beat_a("single_multi", 3'd5, 1'b1, 1'b0, 1'b1);
    tick();
    chk("single_multi.done", 64'(a_ov), 64'd0);

    // Scan 1100_0001 with a 3-cycle stall on the second beat
    a_iv = 1; a_vec = 8'b1100_0001; a_mode = 1;
    tick(); a_iv = 0;
    beat_a("stall0", 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    a_or = 0; a_iv = 1; a_vec = 8'h3C; a_mode = 0;
    for (int s = 0; s < 3; s++) begin
      #1;
      beat_a($sformatf("stall_hold%0d", s), 3'd6, 1'b0, 1'b0, 1'b1);
      chk($sformatf("stall_ir%0d", s), 64'(a_ir), 64'd0);
      tick();
    end
    a_iv = 0; a_or = 1;
    beat_a("stall1", 3'd6, 1'b0, 1'b0, 1'b1);
    tick();
    beat_a("stall2", 3'd7, 1'b1, 1'b0, 1'b1);
    tick();
    chk("stall.done", 64'(a_ov), 64'd0);

    // Back-to-back single vectors with in_valid held high
    a_iv = 1; a_mode = 0; a_vec = 8'h01;
    tick();
    a_vec = 8'h80;
    #1 chk("b2b.ir0", 64'(a_ir), 64'd1);
    beat_a("b2b0", 3'd0, 1'b1, 1'b0, 1'b0);
    tick();
    a_vec = 8'h10;
    #1 chk("b2b.ir1", 64'(a_ir), 64'd1);
    beat_a("b2b1", 3'd7, 1'b1, 1'b0, 1'b0);
    tick();
    a_iv = 0;
    beat_a("b2b2", 3'd4, 1'b1, 1'b0, 1'b0);
    tick();
    chk("b2b.done", 64'(a_ov), 64'd0);

    // Reset mid-scan of 0xFF after two beats
    a_iv = 1; a_vec = 8'hFF; a_mode = 1;
    tick(); a_iv = 0;
    beat_a("rscan0", 3'd0, 1'b0, 1'b0, 1'b1);
    tick();
    beat_a("rscan1", 3'd1, 1'b0, 1'b0, 1'b1);
    tick();
    beat_a("rscan2", 3'd2, 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1 chk("rscan.valid_drop", 64'(a_ov), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rscan.ir", 64'(a_ir), 64'd1);
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("rscan.stale%0d", s), 64'(a_ov), 64'd0);
      tick();
    end

    // Highest-first scan on DUT 1
    b_or = 1; b_iv = 1; b_vec = 8'b1010_0110; b_mode = 1;
    tick(); b_iv = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("msb%0d.valid", k), 64'(b_ov), 64'd1);
      chk($sformatf("msb%0d.idx", k),   64'(b_idx), 64'(exp_b[k]));
      chk($sformatf("msb%0d.last", k),  64'(b_last), 64'(k == 3));
      chk($sformatf("msb%0d.multi", k), 64'(b_multi), 64'd1);
      tick();
    end
    chk("msb.done", 64'(b_ov), 64'd0);

    // N=5 scan 10101 on DUT 2
    c_or = 1; c_iv = 1; c_vec = 5'b10101; c_mode = 1;
    tick(); c_iv = 0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("n5_%0d.valid", k), 64'(c_ov), 64'd1);
      chk($sformatf("n5_%0d.idx", k),   64'(c_idx), 64'(exp_c[k]));
      chk($sformatf("n5_%0d.last", k),  64'(c_last), 64'(k == 2));
      tick();
    end
    chk("n5.done", 64'(c_ov), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
